// File: rtl/alert_icon_scheduler_if.sv
// Pixel-timing, alert-request, icon-ROM and overlay-colour signals of the alert icon scheduler.
// The scheduler side takes the master modport; the VGA path / ROM side takes the slave modport.
interface alert_icon_scheduler_if;
  logic        i_pix_ce;
  logic [10:0] i_x;
  logic [9:0]  i_y;
  logic        i_fire;
  logic        i_warning;
  logic        o_rom_en;
  logic [14:0] o_rom_addr;
  logic [11:0] i_rom_data;
  logic [3:0]  o_red;
  logic [3:0]  o_green;
  logic [3:0]  o_blue;
  logic [1:0]  o_active_icon;

  modport master (
    input  i_pix_ce, i_x, i_y, i_fire, i_warning, i_rom_data,
    output o_rom_en, o_rom_addr, o_red, o_green, o_blue, o_active_icon
  );

  modport slave (
    output i_pix_ce, i_x, i_y, i_fire, i_warning, i_rom_data,
    input  o_rom_en, o_rom_addr, o_red, o_green, o_blue, o_active_icon
  );
endinterface

// File: rtl/alert_icon_scheduler.sv
// Chooses the alert icon once per frame, walks the shared icon ROM in raster order over the
// overlay slot and returns the ROM colour three clocks after each pixel strobe.
module alert_icon_scheduler #(
  parameter int X0           = 521,
  parameter int Y0           = 1,
  parameter int ICON_W       = 120,
  parameter int ICON_H       = 120,
  parameter int WARN_BASE    = 14400,
  parameter int DWELL_FRAMES = 60
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  alert_icon_scheduler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FIRE = 2'b01,
    WARN = 2'b10
  } state_t;

  localparam int          DW         = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [14:0] LAST_OFF   = 15'(ICON_W * ICON_H - 1);
  localparam logic [14:0] WARN_OFF   = 15'(WARN_BASE);
  localparam logic [10:0] X_LO       = 11'(X0);
  localparam logic [10:0] X_HI       = 11'(X0 + ICON_W - 1);
  localparam logic [9:0]  Y_LO       = 10'(Y0);
  localparam logic [9:0]  Y_HI       = 10'(Y0 + ICON_H - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);

  state_t      state;
  state_t      next_state;
  state_t      pix_state;
  logic [DW-1:0] dwell;
  logic [DW-1:0] next_dwell;
  logic [14:0] offset;
  logic [14:0] base_off;
  logic [14:0] next_offset;
  logic [14:0] fetch_addr;
  logic        frame_start;
  logic        in_slot;
  logic        fetch;
  logic        pix_d1;
  logic        pix_d2;
  logic        en_d2;
  logic        rom_en;
  logic [14:0] rom_addr;
  logic [11:0] rgb;

  assign frame_start = bus.i_pix_ce && (bus.i_x == 11'd0) && (bus.i_y == 10'd0);
  assign in_slot     = (bus.i_x >= X_LO) && (bus.i_x <= X_HI) &&
                       (bus.i_y >= Y_LO) && (bus.i_y <= Y_HI);

  // Icon decision taken at frame start; dwell only advances while both alerts compete.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    next_dwell = dwell;
    unique case ({bus.i_fire, bus.i_warning})
      2'b00: begin
        next_state = IDLE;
        next_dwell = '0;
      end
      2'b10: begin
        next_state = FIRE;
        next_dwell = '0;
      end
      2'b01: begin
        next_state = WARN;
        next_dwell = '0;
      end
      default: begin
        if (state == IDLE) begin
          next_state = FIRE;
          next_dwell = '0;
        end else if (dwell == DWELL_LAST) begin
          next_state = (state == FIRE) ? WARN : FIRE;
          next_dwell = '0;
        end else begin
          next_dwell = dwell + DW'(1);
        end
      end
    endcase
  end

  // The frame-start strobe itself is fetched under the newly chosen icon with a fresh offset.
  always_comb begin
    pix_state   = frame_start ? next_state : state;
    base_off    = frame_start ? 15'd0 : offset;
    fetch       = bus.i_pix_ce && in_slot && (pix_state != IDLE);
    fetch_addr  = (pix_state == WARN) ? (WARN_OFF + base_off) : base_off;
    next_offset = base_off;
    if (fetch) begin
      next_offset = (base_off == LAST_OFF) ? 15'd0 : (base_off + 15'd1);
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      dwell    <= '0;
      offset   <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
      pix_d1   <= 1'b0;
      pix_d2   <= 1'b0;
      en_d2    <= 1'b0;
      rgb      <= '0;
    end else begin
      if (frame_start) begin
        state <= next_state;
        dwell <= next_dwell;
      end
      offset <= next_offset;
      rom_en <= fetch;
      if (fetch) begin
        rom_addr <= fetch_addr;
      end
      pix_d1 <= bus.i_pix_ce;
      pix_d2 <= pix_d1;
      en_d2  <= rom_en;
      // Colour changes only on a pixel's third cycle and holds between pixels.
      if (pix_d2) begin
        rgb <= en_d2 ? bus.i_rom_data : 12'd0;
      end
    end
  end

  assign bus.o_rom_en      = rom_en;
  assign bus.o_rom_addr    = rom_addr;
  assign bus.o_red         = rgb[11:8];
  assign bus.o_green       = rgb[7:4];
  assign bus.o_blue        = rgb[3:0];
  assign bus.o_active_icon = state;

endmodule

// File: tb/tb_alert_icon_scheduler.sv
// Directed bench for alert_icon_scheduler: icon selection, slot addressing, dwell rotation,
// mid-frame request drop, mid-frame reset and strobe-spacing independence.
module tb_alert_icon_scheduler;

  logic clk;
  logic rst_n;
  alert_icon_scheduler_if bus ();

  alert_icon_scheduler #(.DWELL_FRAMES(3)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: each word holds the low 12 bits of its own address, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.o_rom_en === 1'b1) bus.i_rom_data <= bus.o_rom_addr[11:0];
  end

  int pulses = 0;
  always @(posedge clk) begin
    if (bus.o_rom_en === 1'b1) pulses <= pulses + 1;
  end

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] en1, addr1, icon0, icon1, en2, rgb2, rgb3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel strobe; samples the pipeline at t+1, t+2, t+3 on falling edges.
  task automatic pixel(input int px, input int py, input int spacing);
    @(negedge clk);
    icon0 = 32'(bus.o_active_icon);
    bus.i_pix_ce = 1'b1;
    bus.i_x = 11'(px);
    bus.i_y = 10'(py);
    @(negedge clk);
    bus.i_pix_ce = 1'b0;
    en1   = 32'(bus.o_rom_en);
    addr1 = 32'(bus.o_rom_addr);
    icon1 = 32'(bus.o_active_icon);
    @(negedge clk);
    en2  = 32'(bus.o_rom_en);
    rgb2 = 32'({bus.o_red, bus.o_green, bus.o_blue});
    @(negedge clk);
    rgb3 = 32'({bus.o_red, bus.o_green, bus.o_blue});
    repeat (spacing - 4) @(negedge clk);
  endtask

  int p_before;
  int exp_icon [7] = '{1, 1, 1, 2, 2, 2, 1};

  initial begin
    rst_n = 1'b0;
    bus.i_pix_ce = 1'b0;
    bus.i_x = '0;
    bus.i_y = '0;
    bus.i_fire = 1'b1;
    bus.i_warning = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_icon", 32'(bus.o_active_icon), 0);
    check("reset_rom_en", 32'(bus.o_rom_en), 0);
    check("reset_rom_addr", 32'(bus.o_rom_addr), 0);
    check("reset_rgb", 32'({bus.o_red, bus.o_green, bus.o_blue}), 0);
    rst_n = 1'b1;

    // Fire held but no frame start yet: stays idle and black.
    pixel(521, 1, 4);
    check("prefs_en", en1, 0);
    check("prefs_icon", icon1, 0);
    check("prefs_rgb", rgb3, 0);

    // First fire frame.
    pixel(0, 0, 4);
    check("fs_fire_icon", icon1, 1);
    check("fs_pixel_en", en1, 0);
    pixel(521, 1, 4);
    check("fire_first_en", en1, 1);
    check("fire_first_addr", addr1, 0);
    check("fire_en_one_cycle", en2, 0);
    pixel(522, 1, 4);
    check("fire_second_addr", addr1, 1);
    check("fire_second_rgb", rgb3, 12'h001);
    pixel(520, 1, 4);
    check("left_edge_en", en1, 0);
    check("left_edge_rgb", rgb3, 0);
    pixel(641, 1, 4);
    check("right_edge_en", en1, 0);
    pixel(521, 0, 4);
    check("top_edge_en", en1, 0);
    pixel(521, 121, 4);
    check("bottom_edge_en", en1, 0);
    pixel(640, 120, 4);
    check("corner_en", en1, 1);
    check("corner_addr", addr1, 2);
    check("corner_rgb", rgb3, 12'h002);
    pixel(600, 60, 4);
    check("drop_pixel_addr", addr1, 3);
    bus.i_fire = 1'b0;
    pixel(601, 60, 4);
    check("after_drop_en", en1, 1);
    check("after_drop_addr", addr1, 4);
    check("after_drop_icon", icon1, 1);

    // No request at frame start: idle frame never touches the ROM.
    pixel(0, 0, 4);
    check("idle_icon", icon1, 0);
    p_before = pulses;
    pixel(521, 1, 4);
    check("idle_en", en1, 0);
    check("idle_rgb", rgb3, 0);
    pixel(580, 60, 4);
    pixel(640, 120, 4);
    check("idle_rgb_last", rgb3, 0);
    check("idle_pulses", 32'(pulses - p_before), 0);

    // Reset in the middle of a fire frame.
    bus.i_fire = 1'b1;
    pixel(0, 0, 4);
    check("fire2_icon", icon1, 1);
    pixel(521, 1, 4);
    pixel(522, 1, 4);
    check("fire2_rgb", rgb3, 12'h001);
    @(negedge clk);
    bus.i_pix_ce = 1'b1;
    bus.i_x = 11'd560;
    bus.i_y = 10'd50;
    @(negedge clk);
    bus.i_pix_ce = 1'b0;
    check("prerst_en", 32'(bus.o_rom_en), 1);
    check("prerst_addr", 32'(bus.o_rom_addr), 2);
    rst_n = 1'b0;
    #1;
    check("rst_en", 32'(bus.o_rom_en), 0);
    check("rst_rgb", 32'({bus.o_red, bus.o_green, bus.o_blue}), 0);
    check("rst_icon", 32'(bus.o_active_icon), 0);
    check("rst_addr", 32'(bus.o_rom_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pixel(561, 50, 4);
    check("postrst_en", en1, 0);
    check("postrst_rgb", rgb3, 0);
    pixel(0, 0, 4);
    pixel(521, 1, 4);
    check("restart_addr0", addr1, 0);
    pixel(522, 1, 4);
    check("restart_addr1", addr1, 1);

    // Both alerts from idle with a three-frame dwell.
    bus.i_fire = 1'b0;
    pixel(0, 0, 4);
    check("dwell_idle_icon", icon1, 0);
    bus.i_fire = 1'b1;
    bus.i_warning = 1'b1;
    for (int f = 0; f < 7; f++) begin
      pixel(0, 0, 4);
      check("dwell_icon_before_fs", icon0, (f == 0) ? 0 : exp_icon[f-1]);
      check("dwell_icon_after_fs", icon1, exp_icon[f]);
      pixel(521, 1, 4);
      check("dwell_first_addr", addr1, (exp_icon[f] == 2) ? 14400 : 0);
    end

    // Full warning frame at 4-cycle spacing.
    bus.i_fire = 1'b0;
    pixel(0, 0, 4);
    check("warn_icon", icon1, 2);
    p_before = pulses;
    for (int yy = 1; yy <= 120; yy++) begin
      for (int xx = 521; xx <= 640; xx++) begin
        pixel(xx, yy, 4);
        check("warn_frame_addr", {15'd0, en1[0], addr1[15:0]},
              32'(32'h1_0000 | (14400 + (yy - 1) * 120 + (xx - 521))));
        if (yy == 1 && xx == 521) check("warn_first_rgb", rgb3, 12'h840);
        if (yy == 120 && xx == 640) begin
          check("warn_last_addr", addr1, 28799);
          check("warn_last_rgb", rgb3, 12'h07F);
        end
      end
    end
    check("warn_frame_pulses", 32'(pulses - p_before), 14400);
    pixel(521, 1, 4);
    check("warn_wrap_addr", addr1, 14400);
    pixel(641, 120, 4);
    check("warn_outside_en", en1, 0);
    check("warn_outside_rgb", rgb3, 0);

    // Same sequence and latency at 7-cycle spacing.
    pixel(0, 0, 7);
    pixel(521, 1, 7);
    check("s7_addr0", addr1, 14400);
    check("s7_rgb0", rgb3, 12'h840);
    pixel(522, 1, 7);
    check("s7_addr1", addr1, 14401);
    check("s7_rgb_t2_held", rgb2, 12'h840);
    check("s7_rgb1", rgb3, 12'h841);
    pixel(523, 1, 7);
    check("s7_addr2", addr1, 14402);
    check("s7_rgb2", rgb3, 12'h842);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
